// File: rtl/mem_lsu.sv
// Memory-access stage: AHB-Lite load/store with alignment checking and write-back register.
module mem_lsu #(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ls_valid,
    input  logic              ls_load,
    input  logic [1:0]        ls_size,
    input  logic              ls_unsigned,
    input  logic [4:0]        ls_rd,
    input  logic [XLEN-1:0]   addr_res,
    input  logic [XLEN-1:0]   st_data,
    input  logic [XLEN-1:0]   ex_res,
    input  logic [4:0]        ex_rd,
    input  logic              ex_wen,
    output logic [XLEN-1:0]   d_haddr,
    output logic [1:0]        d_htrans,
    output logic              d_hwrite,
    output logic [2:0]        d_hsize,
    output logic [XLEN-1:0]   d_hwdata,
    input  logic [XLEN-1:0]   d_hrdata,
    input  logic              d_hready,
    input  logic              d_hresp,
    output logic [XLEN-1:0]   wb_data,
    output logic [4:0]        wb_rd,
    output logic              wb_wen,
    output logic              lsu_stall,
    output logic              misalign,
    output logic              bus_err
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DPHASE = 2'b01,
        ERR    = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic              load_q, load_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [4:0]        rd_q, rd_d;
    logic [1:0]        off_q, off_d;
    logic [XLEN-1:0]   hwdata_q, hwdata_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic              wb_wen_q, wb_wen_d;
    logic              misalign_q, misalign_d;
    logic              bus_err_q, bus_err_d;

    logic [1:0]        size_norm_c;
    logic              aligned_c;
    logic              addr_phase_c;
    logic [XLEN-1:0]   lane_wdata_c;
    logic [7:0]        rbyte_c;
    logic [15:0]       rhalf_c;
    logic [XLEN-1:0]   load_ext_c;

    // Size normalisation, alignment check and address-phase qualifier
    always_comb begin
        size_norm_c = (ls_size == 2'b11) ? 2'b10 : ls_size;
        case (size_norm_c)
            2'b00:   aligned_c = 1'b1;
            2'b01:   aligned_c = ~addr_res[0];
            default: aligned_c = (addr_res[1:0] == 2'b00);
        endcase
        addr_phase_c = rst_n & (state_q == IDLE) & ls_valid & aligned_c;
    end

    // Store-data lane replication by access size
    always_comb begin
        case (size_norm_c)
            2'b00:   lane_wdata_c = {4{st_data[7:0]}};
            2'b01:   lane_wdata_c = {2{st_data[15:0]}};
            default: lane_wdata_c = st_data;
        endcase
    end

    // Load-data lane extraction and sign/zero extension
    always_comb begin
        case (off_q)
            2'b00:   rbyte_c = d_hrdata[7:0];
            2'b01:   rbyte_c = d_hrdata[15:8];
            2'b10:   rbyte_c = d_hrdata[23:16];
            default: rbyte_c = d_hrdata[31:24];
        endcase
        rhalf_c = off_q[1] ? d_hrdata[31:16] : d_hrdata[15:0];
        case (size_q)
            2'b00:   load_ext_c = uns_q ? {24'd0, rbyte_c} : {{24{rbyte_c[7]}}, rbyte_c};
            2'b01:   load_ext_c = uns_q ? {16'd0, rhalf_c} : {{16{rhalf_c[15]}}, rhalf_c};
            default: load_ext_c = d_hrdata;
        endcase
    end

    // Address phase is driven straight from execute while IDLE
    always_comb begin
        d_htrans = addr_phase_c ? HTRANS_NONSEQ : HTRANS_IDLE;
        d_haddr  = addr_phase_c ? addr_res : '0;
        d_hwrite = addr_phase_c & ~ls_load;
        d_hsize  = addr_phase_c ? {1'b0, size_norm_c} : 3'b000;
    end

    // Stall while a transfer is being issued, waited on, or errored
    always_comb begin
        lsu_stall = 1'b0;
        if (rst_n) begin
            case (state_q)
                IDLE:    lsu_stall = addr_phase_c;
                DPHASE:  lsu_stall = ~d_hready | d_hresp;
                ERR:     lsu_stall = 1'b1;
                default: lsu_stall = 1'b0;
            endcase
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        load_d     = load_q;
        size_d     = size_q;
        uns_d      = uns_q;
        rd_d       = rd_q;
        off_d      = off_q;
        hwdata_d   = hwdata_q;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        wb_wen_d   = 1'b0;
        misalign_d = 1'b0;
        bus_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ls_valid) begin
                    if (!aligned_c) begin
                        misalign_d = 1'b1;
                    end else if (d_hready) begin
                        load_d   = ls_load;
                        size_d   = size_norm_c;
                        uns_d    = ls_unsigned;
                        rd_d     = ls_rd;
                        off_d    = addr_res[1:0];
                        hwdata_d = lane_wdata_c;
                        state_d  = DPHASE;
                    end
                end else begin
                    wb_data_d = ex_res;
                    wb_rd_d   = ex_rd;
                    wb_wen_d  = ex_wen;
                end
            end
            DPHASE: begin
                if (d_hresp) begin
                    state_d = ERR;
                end else if (d_hready) begin
                    if (load_q) begin
                        wb_data_d = load_ext_c;
                        wb_rd_d   = rd_q;
                        wb_wen_d  = (rd_q != 5'd0);
                    end
                    state_d = IDLE;
                end
            end
            ERR: begin
                if (d_hready) begin
                    bus_err_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            load_q     <= 1'b0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            rd_q       <= 5'd0;
            off_q      <= 2'b00;
            hwdata_q   <= '0;
            wb_data_q  <= '0;
            wb_rd_q    <= 5'd0;
            wb_wen_q   <= 1'b0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_q     <= load_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            rd_q       <= rd_d;
            off_q      <= off_d;
            hwdata_q   <= hwdata_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            wb_wen_q   <= wb_wen_d;
            misalign_q <= misalign_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign d_hwdata = hwdata_q;
    assign wb_data  = wb_data_q;
    assign wb_rd    = wb_rd_q;
    assign wb_wen   = wb_wen_q;
    assign misalign = misalign_q;
    assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: directed loads/stores, misalignment, bus error, reset abort.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ls_valid, ls_load, ls_unsigned;
    logic [1:0]  ls_size;
    logic [4:0]  ls_rd, ex_rd;
    logic [31:0] addr_res, st_data, ex_res;
    logic        ex_wen;
    logic [31:0] d_haddr, d_hwdata, d_hrdata;
    logic [1:0]  d_htrans;
    logic        d_hwrite;
    logic [2:0]  d_hsize;
    logic        d_hready, d_hresp;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_wen, lsu_stall, misalign, bus_err;

    mem_lsu #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ls_valid(ls_valid), .ls_load(ls_load), .ls_size(ls_size),
        .ls_unsigned(ls_unsigned), .ls_rd(ls_rd),
        .addr_res(addr_res), .st_data(st_data),
        .ex_res(ex_res), .ex_rd(ex_rd), .ex_wen(ex_wen),
        .d_haddr(d_haddr), .d_htrans(d_htrans), .d_hwrite(d_hwrite),
        .d_hsize(d_hsize), .d_hwdata(d_hwdata), .d_hrdata(d_hrdata),
        .d_hready(d_hready), .d_hresp(d_hresp),
        .wb_data(wb_data), .wb_rd(wb_rd), .wb_wen(wb_wen),
        .lsu_stall(lsu_stall), .misalign(misalign), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // kind: 0 = register write, 1 = misalign pulse, 2 = bus error pulse
    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] data;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [1:0] kind, input logic [31:0] data, input logic [4:0] rd);
        exp_t e;
        e.kind = kind;
        e.data = data;
        e.rd   = rd;
        sb.push_back(e);
    endtask

    // Monitor: every write-back or event pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && (wb_wen || misalign || bus_err)) begin
            logic [1:0] ak;
            exp_t       e;
            ak = bus_err ? 2'd2 : (misalign ? 2'd1 : 2'd0);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: kind=%0d wb_wen=%0b data=0x%08h rd=%0d, none expected at %0t",
                         ak, wb_wen, wb_data, wb_rd, $time);
            end else begin
                e = sb.pop_front();
                check("out_kind", 32'(ak), 32'(e.kind));
                check("out_wb_wen", 32'(wb_wen), 32'(e.kind == 2'd0));
                if (e.kind == 2'd0) begin
                    check("wb_data", wb_data, e.data);
                    check("wb_rd", 32'(wb_rd), 32'(e.rd));
                end
            end
        end
    end

    task automatic idle_inputs();
        ls_valid = 1'b0; ls_load = 1'b0; ls_size = 2'b00; ls_unsigned = 1'b0; ls_rd = 5'd0;
        addr_res = 32'd0; st_data = 32'd0; ex_res = 32'd0; ex_rd = 5'd0; ex_wen = 1'b0;
        d_hrdata = 32'd0; d_hready = 1'b1; d_hresp = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic [31:0] res, input logic [4:0] rd);
        ls_valid = 1'b0; ex_res = res; ex_rd = rd; ex_wen = 1'b1;
        push(2'd0, res, rd);
        @(negedge clk);
        check("alu_htrans", 32'(d_htrans), 32'd0);
        check("alu_stall", 32'(lsu_stall), 32'd0);
        @(posedge clk); #1;
        ex_wen = 1'b0;
    endtask

    // One load or store; exp is the write-back value for loads, lane data for stores
    task automatic mem_op(input logic ld, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [4:0] rd, input logic [31:0] sdata,
                          input logic [31:0] rdata, input int waits, input logic [31:0] exp,
                          input logic [2:0] exp_hsize);
        int stalls = 0;
        ls_valid = 1'b1; ls_load = ld; ls_size = size; ls_unsigned = uns; ls_rd = rd;
        addr_res = addr; st_data = sdata; d_hready = 1'b1;
        @(negedge clk);
        check("ap_htrans", 32'(d_htrans), 32'h2);
        check("ap_haddr", d_haddr, addr);
        check("ap_hwrite", 32'(d_hwrite), 32'(!ld));
        check("ap_hsize", 32'(d_hsize), 32'(exp_hsize));
        if (lsu_stall) stalls++;
        @(posedge clk); #1;
        ls_valid = 1'b0;
        d_hready = 1'b0;
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            check("dp_wait_stall", 32'(lsu_stall), 32'd1);
            check("dp_wait_htrans", 32'(d_htrans), 32'd0);
            if (lsu_stall) stalls++;
            @(posedge clk); #1;
        end
        d_hready = 1'b1;
        d_hrdata = rdata;
        if (ld && rd != 5'd0) push(2'd0, exp, rd);
        @(negedge clk);
        if (!ld) check("st_hwdata", d_hwdata, exp);
        check("dp_last_stall", 32'(lsu_stall), 32'd0);
        if (lsu_stall) stalls++;
        check("stall_cycles", 32'(stalls), 32'(waits + 1));
        @(posedge clk); #1;
        d_hrdata = 32'd0;
        @(negedge clk);
        check("wb_latency", 32'(wb_wen), 32'(ld && rd != 5'd0));
        @(posedge clk); #1;
    endtask

    task automatic misaligned(input logic [31:0] addr, input logic [1:0] size);
        ls_valid = 1'b1; ls_load = 1'b1; ls_size = size; ls_rd = 5'd12; addr_res = addr;
        push(2'd1, 32'd0, 5'd0);
        @(negedge clk);
        check("mis_htrans", 32'(d_htrans), 32'd0);
        check("mis_stall", 32'(lsu_stall), 32'd0);
        @(posedge clk); #1;
        ls_valid = 1'b0;
        cycles(3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no completion expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        ls_valid = 1'b1; ls_load = 1'b1; ls_size = 2'b10; addr_res = 32'h0000_0100;
        cycles(2);
        @(negedge clk);
        check("rst_htrans", 32'(d_htrans), 32'd0);
        check("rst_haddr", d_haddr, 32'd0);
        check("rst_stall", 32'(lsu_stall), 32'd0);
        check("rst_wb_wen", 32'(wb_wen), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_hwdata", d_hwdata, 32'd0);
        idle_inputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycles(1);

        alu(32'h1234_5678, 5'd5);
        cycles(1);
        mem_op(1'b1, 32'h0000_1003, 2'b00, 1'b0, 5'd3, 32'd0, 32'h80FF_0000, 0, 32'hFFFF_FF80, 3'b000);
        mem_op(1'b1, 32'h0000_1003, 2'b00, 1'b1, 5'd4, 32'd0, 32'h80FF_0000, 0, 32'h0000_0080, 3'b000);
        mem_op(1'b1, 32'h0000_2002, 2'b01, 1'b0, 5'd6, 32'd0, 32'h8001_1234, 1, 32'hFFFF_8001, 3'b001);
        mem_op(1'b1, 32'h0000_2000, 2'b01, 1'b1, 5'd8, 32'd0, 32'h8001_F234, 0, 32'h0000_F234, 3'b001);
        mem_op(1'b0, 32'h0000_2002, 2'b01, 1'b0, 5'd0, 32'hAAAA_BEEF, 32'd0, 2, 32'hBEEF_BEEF, 3'b001);
        mem_op(1'b0, 32'h0000_0011, 2'b00, 1'b0, 5'd0, 32'h1234_56AB, 32'd0, 0, 32'hABAB_ABAB, 3'b000);
        mem_op(1'b1, 32'h0000_6000, 2'b11, 1'b0, 5'd9, 32'd0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 3'b010);
        mem_op(1'b1, 32'h0000_6004, 2'b10, 1'b0, 5'd0, 32'd0, 32'h5555_AAAA, 0, 32'h5555_AAAA, 3'b010);

        misaligned(32'h0000_3001, 2'b10);
        misaligned(32'h0000_3003, 2'b01);

        // Bus error: two-cycle AHB error response
        ls_valid = 1'b1; ls_load = 1'b1; ls_size = 2'b10; ls_rd = 5'd11; addr_res = 32'h0000_4000;
        @(posedge clk); #1;
        ls_valid = 1'b0; d_hready = 1'b0; d_hresp = 1'b1;
        @(negedge clk);
        check("err_dp_stall", 32'(lsu_stall), 32'd1);
        @(posedge clk); #1;
        d_hready = 1'b1;
        push(2'd2, 32'd0, 5'd0);
        @(negedge clk);
        check("err_state_stall", 32'(lsu_stall), 32'd1);
        @(posedge clk); #1;
        d_hresp = 1'b0;
        @(negedge clk);
        check("err_bus_err", 32'(bus_err), 32'd1);
        check("err_back_idle", 32'(lsu_stall), 32'd0);
        @(posedge clk); #1;
        alu(32'h0BAD_F00D, 5'd10);
        cycles(2);

        // Reset during a data-phase wait state
        ls_valid = 1'b1; ls_load = 1'b1; ls_size = 2'b10; ls_rd = 5'd13; addr_res = 32'h0000_7000;
        @(posedge clk); #1;
        ls_valid = 1'b1; addr_res = 32'h0000_7100; d_hready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_htrans", 32'(d_htrans), 32'd0);
        check("rstmid_stall", 32'(lsu_stall), 32'd0);
        check("rstmid_wb_wen", 32'(wb_wen), 32'd0);
        check("rstmid_wb_data", wb_data, 32'd0);
        check("rstmid_wb_rd", 32'(wb_rd), 32'd0);
        idle_inputs();
        cycles(2);
        rst_n = 1'b1;
        cycles(1);
        mem_op(1'b1, 32'h0000_5000, 2'b10, 1'b0, 5'd7, 32'd0, 32'hCAFE_F00D, 1, 32'hCAFE_F00D, 3'b010);
        cycles(3);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
